// File: rtl/adder_arbiter.sv
// adder_arbiter: shares one N-bit add/pass datapath among NREQ requesters.
// One grant per cycle. The result sits in a one-deep output register with
// valid/ready back-pressure.
// Define ADDER_ARBITER_RR_EN for round-robin arbitration. The default build
// uses fixed priority, where the lowest asserted index wins.
module adder_arbiter #(
  parameter int unsigned N    = 32,
  parameter int unsigned NREQ = 4,
  parameter int unsigned IDW  = $clog2(NREQ)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NREQ-1:0]   req_valid,
  output logic [NREQ-1:0]   req_ready,
  input  logic [NREQ*N-1:0] req_a,
  input  logic [NREQ*N-1:0] req_b,
  input  logic [NREQ*2-1:0] req_op,
  output logic              res_valid,
  input  logic              res_ready,
  output logic [N-1:0]      res_data,
  output logic              res_carry,
  output logic [IDW-1:0]    res_id,
  output logic [15:0]       res_count
);

  logic            r_res_valid;
  logic [N-1:0]    r_res_data;
  logic            r_res_carry;
  logic [IDW-1:0]  r_res_id;
  logic [15:0]     r_res_count;

  logic            w_can_take;
  logic            w_gnt_any;
  logic [IDW-1:0]  w_gnt_idx;
  logic [IDW-1:0]  w_cand;
  logic            w_xfer;
  logic [N-1:0]    w_a;
  logic [N-1:0]    w_b;
  logic [1:0]      w_op;
  logic [N:0]      w_sum;
  logic [N-1:0]    w_result;
  logic            w_carry;

`ifdef ADDER_ARBITER_RR_EN
  logic [IDW-1:0]  r_ptr;
`endif

  // Grants are held off while reset is asserted, so req_ready drops at once.
  assign w_can_take = !rst && (!r_res_valid || res_ready);
  assign w_xfer     = w_can_take && w_gnt_any;
  assign req_ready  = w_xfer ? (NREQ'(1) << w_gnt_idx) : '0;

  // Pick the first valid requester, searching upward from the start index
  always_comb begin
    w_gnt_any = 1'b0;
    w_gnt_idx = '0;
    w_cand    = '0;
    for (int unsigned k = 0; k < NREQ; k++) begin
`ifdef ADDER_ARBITER_RR_EN
      w_cand = IDW'((32'(r_ptr) + k) % NREQ);
`else
      w_cand = IDW'(k);
`endif
      if (!w_gnt_any && req_valid[w_cand]) begin
        w_gnt_any = 1'b1;
        w_gnt_idx = w_cand;
      end
    end
  end

  // Route the granted requester's operands and op code to the shared datapath
  always_comb begin
    w_a  = '0;
    w_b  = '0;
    w_op = '0;
    for (int unsigned k = 0; k < NREQ; k++) begin
      if (IDW'(k) == w_gnt_idx) begin
        w_a  = req_a[k*N +: N];
        w_b  = req_b[k*N +: N];
        w_op = req_op[k*2 +: 2];
      end
    end
  end

  assign w_sum = {1'b0, w_a} + {1'b0, w_b};

  // Op decode: sel_b wins, then sum, otherwise pass A; carry only for the sum
  always_comb begin
    w_result = w_a;
    w_carry  = 1'b0;
    if (w_op[1]) begin
      w_result = w_b;
    end else if (w_op[0]) begin
      w_result = w_sum[N-1:0];
      w_carry  = w_sum[N];
    end
  end

  // Result register: reload on transfer, otherwise clear when drained
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_res_valid <= 1'b0;
      r_res_data  <= '0;
      r_res_carry <= 1'b0;
      r_res_id    <= '0;
    end else if (w_xfer) begin
      r_res_valid <= 1'b1;
      r_res_data  <= w_result;
      r_res_carry <= w_carry;
      r_res_id    <= w_gnt_idx;
    end else if (res_ready) begin
      r_res_valid <= 1'b0;
    end
  end

  // Count completed output handshakes; wraps naturally at 16 bits
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_res_count <= '0;
    end else if (r_res_valid && res_ready) begin
      r_res_count <= r_res_count + 16'd1;
    end
  end

`ifdef ADDER_ARBITER_RR_EN
  // Advance the search start to just past the last granted requester
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ptr <= '0;
    end else if (w_xfer) begin
      r_ptr <= (w_gnt_idx == IDW'(NREQ-1)) ? '0 : w_gnt_idx + IDW'(1);
    end
  end
`endif

  assign res_valid = r_res_valid;
  assign res_data  = r_res_data;
  assign res_carry = r_res_carry;
  assign res_id    = r_res_id;
  assign res_count = r_res_count;

endmodule

// File: tb/tb_adder_arbiter.sv
// Directed bench for adder_arbiter (N=32, NREQ=4).
// Expected values follow the arbitration mode selected by ADDER_ARBITER_RR_EN.
module tb_adder_arbiter;
  localparam int unsigned N    = 32;
  localparam int unsigned NREQ = 4;
  localparam int unsigned IDW  = 2;
`ifdef ADDER_ARBITER_RR_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              rst;
  logic [NREQ-1:0]   req_valid;
  logic [NREQ-1:0]   req_ready;
  logic [NREQ*N-1:0] req_a;
  logic [NREQ*N-1:0] req_b;
  logic [NREQ*2-1:0] req_op;
  logic              res_valid;
  logic              res_ready;
  logic [N-1:0]      res_data;
  logic              res_carry;
  logic [IDW-1:0]    res_id;
  logic [15:0]       res_count;

  int n_checks = 0;
  int n_errors = 0;

  adder_arbiter #(.N(N), .NREQ(NREQ), .IDW(IDW)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b), .req_op(req_op),
    .res_valid(res_valid), .res_ready(res_ready),
    .res_data(res_data), .res_carry(res_carry),
    .res_id(res_id), .res_count(res_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic set_req(input int unsigned idx, input logic [31:0] a,
                         input logic [31:0] b, input logic [1:0] op);
    req_a[idx*N +: N] = a;
    req_b[idx*N +: N] = b;
    req_op[idx*2 +: 2] = op;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  logic [1:0]  op_tab  [4] = '{2'b01, 2'b00, 2'b10, 2'b11};
  logic [31:0] dat_tab [4] = '{32'h0, 32'hFFFF_FFFF, 32'h1, 32'h1};
  logic        cy_tab  [4] = '{1'b1, 1'b0, 1'b0, 1'b0};

  initial begin
    rst = 1'b1; req_valid = '0; req_a = '0; req_b = '0; req_op = '0; res_ready = 1'b0;
    #2;
    chk("rst_valid", res_valid, 0);
    chk("rst_data",  res_data, 0);
    chk("rst_carry", res_carry, 0);
    chk("rst_id",    res_id, 0);
    chk("rst_count", res_count, 0);
    chk("rst_ready", req_ready, 0);

    // single request: 5 + 7
    @(negedge clk); rst = 1'b0; res_ready = 1'b1;
    set_req(0, 32'd5, 32'd7, 2'b01); req_valid = 4'b0001;
    #1 chk("single_rdy", req_ready, 4'b0001);
    tick();
    chk("single_valid", res_valid, 1);
    chk("single_data",  res_data, 12);
    chk("single_carry", res_carry, 0);
    chk("single_id",    res_id, 0);
    @(negedge clk); req_valid = '0;
    tick();
    chk("drain_valid", res_valid, 0);
    chk("drain_count", res_count, 1);

    // ops and carry, back to back
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      set_req(0, 32'hFFFF_FFFF, 32'd1, op_tab[i]); req_valid = 4'b0001;
      tick();
      chk("op_valid", res_valid, 1);
      chk("op_data",  res_data, dat_tab[i]);
      chk("op_carry", res_carry, cy_tab[i]);
    end
    @(negedge clk); req_valid = '0;
    tick();
    chk("op_count", res_count, 5);

    // fairness: all valid, A=i, B=100 -> data 100+i
    @(negedge clk);
    for (int i = 0; i < 4; i++) set_req(i, i, 32'd100, 2'b01);
    req_valid = 4'hF;
    for (int k = 0; k < 8; k++) begin
      tick();
      chk("fair_valid", res_valid, 1);
      chk("fair_id",   res_id,   RR ? (k + 1) % 4 : 0);
      chk("fair_data", res_data, RR ? 100 + (k + 1) % 4 : 100);
    end
    chk("fair_count", res_count, 12);

    // back-pressure: hold the result for 5 cycles
    @(negedge clk); res_ready = 1'b0;
    #1 chk("bp_rdy0", req_ready, 0);
    for (int k = 0; k < 5; k++) begin
      tick();
      chk("bp_valid", res_valid, 1);
      chk("bp_data",  res_data, 100);
      chk("bp_rdy",   req_ready, 0);
      chk("bp_count", res_count, 12);
    end
    @(negedge clk); res_ready = 1'b1;
    #1 chk("bp_release_rdy", req_ready, RR ? 4'b0010 : 4'b0001);
    tick();
    chk("bp_next_valid", res_valid, 1);
    chk("bp_next_id",    res_id, RR ? 1 : 0);
    chk("bp_next_data",  res_data, RR ? 101 : 100);
    chk("bp_next_count", res_count, 13);
    @(negedge clk); req_valid = '0;
    tick();
    chk("bp_drain_valid", res_valid, 0);
    chk("bp_drain_count", res_count, 14);

    // reset mid-operation
    @(negedge clk); res_ready = 1'b0; req_valid = 4'b0100;
    tick();
    chk("pre_rst_valid", res_valid, 1);
    chk("pre_rst_id",    res_id, 2);
    chk("pre_rst_data",  res_data, 102);
    @(negedge clk); rst = 1'b1;
    #1;
    chk("mid_rst_valid", res_valid, 0);
    chk("mid_rst_count", res_count, 0);
    chk("mid_rst_ready", req_ready, 0);
    chk("mid_rst_data",  res_data, 0);
    @(negedge clk); rst = 1'b0; req_valid = 4'b1010;
    #1 chk("post_rst_ptr", req_ready, 4'b0010);
    #1 req_valid = 4'b0100;
    #1 chk("post_rst_rdy2", req_ready, 4'b0100);
    res_ready = 1'b1;
    tick();
    chk("post_rst_id",    res_id, 2);
    chk("post_rst_data",  res_data, 102);
    chk("post_rst_count", res_count, 0);

    // counter wrap: 65537 handshakes in total
    @(negedge clk);
    set_req(0, 32'd3, 32'd4, 2'b01); req_valid = 4'b0001;
    repeat (65535) @(posedge clk);
    #1 chk("wrap_ffff", res_count, 16'hFFFF);
    tick();
    chk("wrap_zero", res_count, 0);
    chk("wrap_data", res_data, 7);
    @(negedge clk); req_valid = '0;
    tick();
    chk("wrap_one",   res_count, 1);
    chk("wrap_valid", res_valid, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
